// File: rtl/spio_hss_multiplexer_pkt_sched_pkg.sv
// Shared constants and FSM state encoding for the HSS multiplexer frame packet scheduler.
package spio_hss_multiplexer_pkt_sched_pkg;

    localparam int PKT_BITS     = 72;
    localparam int DEF_NUM_CH   = 8;
    localparam int DEF_FRM_PKTS = 4;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_ARB  = 2'd1,
        SCHED_XFER = 2'd2,
        SCHED_DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/spio_hss_multiplexer_pkt_sched_if.sv
// Bundle between the channel dispatch FIFOs, the scheduler and the frame assembler.
interface spio_hss_multiplexer_pkt_sched_if
    import spio_hss_multiplexer_pkt_sched_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int PKT_BITS = spio_hss_multiplexer_pkt_sched_pkg::PKT_BITS
);
    localparam int CH_BITS = $clog2(NUM_CH);

    logic                       frm_start;
    logic [NUM_CH-1:0]          ch_stop;
    logic [NUM_CH*PKT_BITS-1:0] ch_pkt_data;
    logic [NUM_CH-1:0]          ch_pkt_vld;
    logic [NUM_CH-1:0]          ch_pkt_rdy;
    logic [PKT_BITS-1:0]        frm_pkt_data;
    logic [CH_BITS-1:0]         frm_pkt_ch;
    logic                       frm_pkt_vld;
    logic                       frm_pkt_rdy;
    logic                       frm_done;
    logic [3:0]                 frm_cnt;
    logic                       busy;

    // The scheduler is the master; FIFOs and assembler together form the slave side.
    modport master (
        input  frm_start, ch_stop, ch_pkt_data, ch_pkt_vld, frm_pkt_rdy,
        output ch_pkt_rdy, frm_pkt_data, frm_pkt_ch, frm_pkt_vld, frm_done, frm_cnt, busy
    );

    modport slave (
        output frm_start, ch_stop, ch_pkt_data, ch_pkt_vld, frm_pkt_rdy,
        input  ch_pkt_rdy, frm_pkt_data, frm_pkt_ch, frm_pkt_vld, frm_done, frm_cnt, busy
    );

endinterface

// File: rtl/spio_hss_multiplexer_rr_arb.sv
// Combinational round-robin picker: first request at or after the pointer, wrapping upward.
module spio_hss_multiplexer_rr_arb
    import spio_hss_multiplexer_pkt_sched_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CH_BITS = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]  i_req,
    input  logic [CH_BITS-1:0] i_ptr,
    output logic [NUM_CH-1:0]  o_gnt,
    output logic [CH_BITS-1:0] o_idx,
    output logic               o_any
);

    always_comb begin
        logic [CH_BITS-1:0] w_idx;
        w_idx = '0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        // NUM_CH is a power of two, so the pointer sum wraps by truncation.
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = i_ptr + CH_BITS'(i);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_idx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/spio_hss_multiplexer_pkt_sched.sv
// Frame packet scheduler: drains up to FRM_PKTS packets round-robin per frame request.
// Define SPIO_HSS_MUX_SCHED_STOP_EN to let ch_stop mask channel eligibility.
module spio_hss_multiplexer_pkt_sched
    import spio_hss_multiplexer_pkt_sched_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int FRM_PKTS = DEF_FRM_PKTS
) (
    input logic clk,
    input logic rst,
    spio_hss_multiplexer_pkt_sched_if.master bus
);

    localparam int CH_BITS = $clog2(NUM_CH);

    sched_state_e        r_state;
    sched_state_e        w_state_next;
    logic [CH_BITS-1:0]  r_rr_ptr;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic [3:0]          r_frm_cnt;
    logic [PKT_BITS-1:0] r_pkt_data;
    logic [CH_BITS-1:0]  r_pkt_ch;
    logic                r_pkt_vld;
    logic [NUM_CH-1:0]   w_eligible;
    logic [NUM_CH-1:0]   w_gnt;
    logic [CH_BITS-1:0]  w_win_idx;
    logic                w_any;
    logic                w_accept;

`ifdef SPIO_HSS_MUX_SCHED_STOP_EN
    assign w_eligible = bus.ch_pkt_vld & ~bus.ch_stop;
`else
    assign w_eligible = bus.ch_pkt_vld;
`endif

    spio_hss_multiplexer_rr_arb #(
        .NUM_CH  (NUM_CH),
        .CH_BITS (CH_BITS)
    ) u_rr_arb (
        .i_req (w_eligible),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_win_idx),
        .o_any (w_any)
    );

    assign w_accept = (r_state == SCHED_XFER) && bus.frm_pkt_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SCHED_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SCHED_IDLE: if (bus.frm_start) w_state_next = SCHED_ARB;
            SCHED_ARB:  w_state_next = w_any ? SCHED_XFER : SCHED_DONE;
            SCHED_XFER: if (w_accept) w_state_next = (w_cnt_next == 4'(FRM_PKTS)) ? SCHED_DONE : SCHED_ARB;
            SCHED_DONE: w_state_next = SCHED_IDLE;
            default:    w_state_next = SCHED_IDLE;
        endcase
    end

    always_comb begin
        bus.ch_pkt_rdy = '0;
        bus.frm_done   = 1'b0;
        bus.busy       = (r_state != SCHED_IDLE);
        case (r_state)
            SCHED_ARB:  bus.ch_pkt_rdy = w_gnt;
            SCHED_DONE: bus.frm_done   = 1'b1;
            default:    ;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if ((r_state == SCHED_IDLE) && bus.frm_start) begin
            w_cnt_next = '0;
        end else if (w_accept) begin
            w_cnt_next = r_cnt + 4'd1;
        end
    end

    // frm_cnt is loaded on entry to DONE so it is already valid alongside the frm_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_frm_cnt  <= '0;
            r_pkt_data <= '0;
            r_pkt_ch   <= '0;
            r_pkt_vld  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            if ((r_state == SCHED_ARB) && w_any) begin
                r_pkt_data <= bus.ch_pkt_data[int'(w_win_idx)*PKT_BITS +: PKT_BITS];
                r_pkt_ch   <= w_win_idx;
                r_pkt_vld  <= 1'b1;
                r_rr_ptr   <= w_win_idx + CH_BITS'(1);
            end else if (w_accept) begin
                r_pkt_vld  <= 1'b0;
            end
            if ((w_state_next == SCHED_DONE) && (r_state != SCHED_DONE)) begin
                r_frm_cnt <= w_cnt_next;
            end
        end
    end

    assign bus.frm_pkt_data = r_pkt_data;
    assign bus.frm_pkt_ch   = r_pkt_ch;
    assign bus.frm_pkt_vld  = r_pkt_vld;
    assign bus.frm_cnt      = r_frm_cnt;

endmodule

// File: tb/tb_spio_hss_multiplexer_pkt_sched.sv
// Directed bench for the frame packet scheduler, with a small channel-FIFO model feeding it.
module tb_spio_hss_multiplexer_pkt_sched;
    import spio_hss_multiplexer_pkt_sched_pkg::*;

    localparam int NCH = 8;
    localparam int FP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spio_hss_multiplexer_pkt_sched_if #(.NUM_CH(NCH), .PKT_BITS(PKT_BITS)) bus ();

    spio_hss_multiplexer_pkt_sched #(.NUM_CH(NCH), .FRM_PKTS(FP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int fifoCnt [NCH];
    int seqNo   [NCH];
    logic [NCH-1:0] pendingPop = '0;
    int popTotal = 0;
    int rxCh [$];
    logic [PKT_BITS-1:0] rxData [$];

    function automatic logic [PKT_BITS-1:0] pktWord(input int ch, input int seq);
        return {8'(ch), 32'(seq), 32'hC0DE_0000};
    endfunction

    // Each channel FIFO head shows its tag and sequence number while it holds packets.
    always_comb begin
        bus.ch_pkt_vld  = '0;
        bus.ch_pkt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.ch_pkt_vld[i] = (fifoCnt[i] != 0);
            bus.ch_pkt_data[i*PKT_BITS +: PKT_BITS] = pktWord(i, seqNo[i]);
        end
    end

    // A pop strobed during an ARB cycle advances that FIFO during the following cycle.
    always @(negedge clk) begin
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (pendingPop[i]) begin
                if (fifoCnt[i] > 0) fifoCnt[i] = fifoCnt[i] - 1;
                seqNo[i] = seqNo[i] + 1;
            end
        end
        #1;
        pendingPop = bus.ch_pkt_rdy;
        popTotal   = popTotal + $countones(bus.ch_pkt_rdy);
    end

    always @(negedge clk) begin
        #1;
        if (!rst && bus.frm_pkt_vld && bus.frm_pkt_rdy) begin
            rxCh.push_back(int'(bus.frm_pkt_ch));
            rxData.push_back(bus.frm_pkt_data);
        end
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic setFifos(input int c0, input int c1, input int c2, input int c3,
                            input int c4, input int c5, input int c6, input int c7);
        fifoCnt[0] = c0; fifoCnt[1] = c1; fifoCnt[2] = c2; fifoCnt[3] = c3;
        fifoCnt[4] = c4; fifoCnt[5] = c5; fifoCnt[6] = c6; fifoCnt[7] = c7;
    endtask

    task automatic startFrame();
        @(negedge clk);
        bus.frm_start = 1'b1;
        @(negedge clk);
        bus.frm_start = 1'b0;
        #3;
    endtask

    task automatic waitDone(input int maxCyc, output int cyc, output bit seen, output logic [3:0] cnt);
        seen = 1'b0;
        cyc  = 0;
        cnt  = 'x;
        while (!seen && cyc < maxCyc) begin
            @(negedge clk);
            #3;
            cyc++;
            if (bus.frm_done === 1'b1) begin
                seen = 1'b1;
                cnt  = bus.frm_cnt;
            end
        end
    endtask

    task automatic test_reset();
        bus.frm_start   = 1'b0;
        bus.ch_stop     = '0;
        bus.frm_pkt_rdy = 1'b1;
        setFifos(0, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #3;
        checks++; if (bus.frm_pkt_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %0b want 0", bus.frm_pkt_vld); end
        checks++; if (bus.frm_pkt_data !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", bus.frm_pkt_data); end
        checks++; if (bus.frm_pkt_ch !== 3'd0) begin errors++; $display("[TB] FAIL reset_ch: got %0d want 0", bus.frm_pkt_ch); end
        checks++; if (bus.frm_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", bus.frm_done); end
        checks++; if (bus.frm_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", bus.frm_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.ch_pkt_rdy !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdy: got %h want 00", bus.ch_pkt_rdy); end
        setFifos(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full_frame();
        int cyc; bit seen; logic [3:0] cnt; int popBase;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) setFifos(2, 2, 2, 2, 2, 2, 2, 2);
            rxCh.delete(); rxData.delete();
            popBase = popTotal;
            startFrame();
            waitDone(40, cyc, seen, cnt);
            checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL full_done_seen frame %0d: got %0b want 1", f, seen); end
            checks++; if (cyc != 2 * FP) begin errors++; $display("[TB] FAIL full_latency frame %0d: got %0d want %0d", f, cyc, 2 * FP); end
            checks++; if (cnt !== 4'd4) begin errors++; $display("[TB] FAIL full_frm_cnt frame %0d: got %0d want 4", f, cnt); end
            checks++; if (popTotal - popBase != 4) begin errors++; $display("[TB] FAIL full_pops frame %0d: got %0d want 4", f, popTotal - popBase); end
            checks++; if (rxCh.size() != 4) begin errors++; $display("[TB] FAIL full_rx_size frame %0d: got %0d want 4", f, rxCh.size()); end
            for (int k = 0; k < 4 && k < rxCh.size(); k++) begin
                checks++; if (rxCh[k] != 4 * f + k) begin errors++; $display("[TB] FAIL full_ch frame %0d pkt %0d: got %0d want %0d", f, k, rxCh[k], 4 * f + k); end
                checks++; if (rxData[k] !== pktWord(4 * f + k, 0)) begin errors++; $display("[TB] FAIL full_data frame %0d pkt %0d: got %h want %h", f, k, rxData[k], pktWord(4 * f + k, 0)); end
            end
        end
    endtask

    task automatic test_early_close();
        int cyc; bit seen; logic [3:0] cnt;
        setFifos(0, 0, 0, 0, 0, 2, 0, 0);
        rxCh.delete(); rxData.delete();
        startFrame();
        waitDone(40, cyc, seen, cnt);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL early_done_seen: got %0b want 1", seen); end
        checks++; if (cyc != 5) begin errors++; $display("[TB] FAIL early_latency: got %0d want 5", cyc); end
        checks++; if (cnt !== 4'd2) begin errors++; $display("[TB] FAIL early_frm_cnt: got %0d want 2", cnt); end
        checks++; if (rxCh.size() != 2) begin errors++; $display("[TB] FAIL early_rx_size: got %0d want 2", rxCh.size()); end
        for (int k = 0; k < 2 && k < rxCh.size(); k++) begin
            checks++; if (rxCh[k] != 5) begin errors++; $display("[TB] FAIL early_ch pkt %0d: got %0d want 5", k, rxCh[k]); end
            checks++; if (rxData[k] !== pktWord(5, k + 1)) begin errors++; $display("[TB] FAIL early_data pkt %0d: got %h want %h", k, rxData[k], pktWord(5, k + 1)); end
        end
    endtask

    task automatic test_empty_frame();
        int popBase;
        setFifos(0, 0, 0, 0, 0, 0, 0, 0);
        popBase = popTotal;
        startFrame();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL empty_busy_arb: got %0b want 1", bus.busy); end
        checks++; if (bus.frm_done !== 1'b0) begin errors++; $display("[TB] FAIL empty_done_early: got %0b want 0", bus.frm_done); end
        checks++; if (bus.ch_pkt_rdy !== 8'h00) begin errors++; $display("[TB] FAIL empty_rdy: got %h want 00", bus.ch_pkt_rdy); end
        @(negedge clk); #3;
        checks++; if (bus.frm_done !== 1'b1) begin errors++; $display("[TB] FAIL empty_done: got %0b want 1", bus.frm_done); end
        checks++; if (bus.frm_cnt !== 4'd0) begin errors++; $display("[TB] FAIL empty_frm_cnt: got %0d want 0", bus.frm_cnt); end
        @(negedge clk); #3;
        checks++; if (bus.frm_done !== 1'b0) begin errors++; $display("[TB] FAIL empty_done_width: got %0b want 0", bus.frm_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL empty_busy_idle: got %0b want 0", bus.busy); end
        checks++; if (popTotal != popBase) begin errors++; $display("[TB] FAIL empty_pops: got %0d want 0", popTotal - popBase); end
    endtask

    task automatic test_stop_mask();
        int cyc; bit seen; logic [3:0] cnt;
        int expCh [$];
        int expCyc;
        logic [3:0] expCnt;
`ifdef SPIO_HSS_MUX_SCHED_STOP_EN
        expCh  = '{1, 3};
        expCyc = 5;
        expCnt = 4'd2;
`else
        expCh  = '{0, 1, 2, 3};
        expCyc = 8;
        expCnt = 4'd4;
`endif
        setFifos(1, 1, 1, 1, 0, 0, 0, 0);
        bus.ch_stop = 8'h05;
        rxCh.delete(); rxData.delete();
        startFrame();
        waitDone(40, cyc, seen, cnt);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL stop_done_seen: got %0b want 1", seen); end
        checks++; if (cyc != expCyc) begin errors++; $display("[TB] FAIL stop_latency: got %0d want %0d", cyc, expCyc); end
        checks++; if (cnt !== expCnt) begin errors++; $display("[TB] FAIL stop_frm_cnt: got %0d want %0d", cnt, expCnt); end
        checks++; if (rxCh.size() != expCh.size()) begin errors++; $display("[TB] FAIL stop_rx_size: got %0d want %0d", rxCh.size(), expCh.size()); end
        for (int k = 0; k < expCh.size() && k < rxCh.size(); k++) begin
            checks++; if (rxCh[k] != expCh[k]) begin errors++; $display("[TB] FAIL stop_ch pkt %0d: got %0d want %0d", k, rxCh[k], expCh[k]); end
        end
        bus.ch_stop = '0;
        setFifos(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_stall();
        int cyc; bit seen; logic [3:0] cnt; int popBase;
        logic [PKT_BITS-1:0] expData;
        expData = pktWord(6, 1);
        setFifos(0, 0, 1, 0, 0, 0, 1, 0);
        bus.frm_pkt_rdy = 1'b0;
        rxCh.delete(); rxData.delete();
        popBase = popTotal;
        startFrame();
        @(negedge clk); #3;
        checks++; if (bus.frm_pkt_vld !== 1'b1) begin errors++; $display("[TB] FAIL stall_vld_rise: got %0b want 1", bus.frm_pkt_vld); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.frm_start = (i % 3 == 0);
            #3;
            checks++; if (bus.frm_pkt_vld !== 1'b1) begin errors++; $display("[TB] FAIL stall_vld cyc %0d: got %0b want 1", i, bus.frm_pkt_vld); end
            checks++; if (bus.frm_pkt_ch !== 3'd6) begin errors++; $display("[TB] FAIL stall_ch cyc %0d: got %0d want 6", i, bus.frm_pkt_ch); end
            checks++; if (bus.frm_pkt_data !== expData) begin errors++; $display("[TB] FAIL stall_data cyc %0d: got %h want %h", i, bus.frm_pkt_data, expData); end
            checks++; if (bus.ch_pkt_rdy !== 8'h00) begin errors++; $display("[TB] FAIL stall_rdy cyc %0d: got %h want 00", i, bus.ch_pkt_rdy); end
        end
        checks++; if (popTotal - popBase != 1) begin errors++; $display("[TB] FAIL stall_pops_held: got %0d want 1", popTotal - popBase); end
        @(negedge clk);
        bus.frm_start   = 1'b0;
        bus.frm_pkt_rdy = 1'b1;
        waitDone(40, cyc, seen, cnt);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL stall_done_seen: got %0b want 1", seen); end
        checks++; if (cnt !== 4'd2) begin errors++; $display("[TB] FAIL stall_frm_cnt: got %0d want 2", cnt); end
        checks++; if (rxCh.size() != 2) begin errors++; $display("[TB] FAIL stall_rx_size: got %0d want 2", rxCh.size()); end
        if (rxCh.size() == 2) begin
            checks++; if (rxCh[0] != 6) begin errors++; $display("[TB] FAIL stall_ch0: got %0d want 6", rxCh[0]); end
            checks++; if (rxCh[1] != 2) begin errors++; $display("[TB] FAIL stall_ch1: got %0d want 2", rxCh[1]); end
        end
        repeat (2) begin
            @(negedge clk); #3;
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL stall_start_ignored: got busy %0b want 0", bus.busy); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc; bit seen; logic [3:0] cnt;
        setFifos(0, 1, 0, 0, 0, 1, 0, 0);
        bus.frm_pkt_rdy = 1'b0;
        rxCh.delete(); rxData.delete();
        startFrame();
        @(negedge clk); #3;
        checks++; if (bus.frm_pkt_ch !== 3'd5) begin errors++; $display("[TB] FAIL rstmid_held_ch: got %0d want 5", bus.frm_pkt_ch); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #3;
        checks++; if (bus.frm_pkt_vld !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_vld: got %0b want 0", bus.frm_pkt_vld); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.frm_done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done: got %0b want 0", bus.frm_done); end
        checks++; if (bus.frm_cnt !== 4'd0) begin errors++; $display("[TB] FAIL rstmid_frm_cnt: got %0d want 0", bus.frm_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #3;
        checks++; if (bus.frm_done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done_after: got %0b want 0", bus.frm_done); end
        fifoCnt[4] = 1;
        bus.frm_pkt_rdy = 1'b1;
        rxCh.delete(); rxData.delete();
        startFrame();
        waitDone(40, cyc, seen, cnt);
        checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_next_done: got %0b want 1", seen); end
        checks++; if (cnt !== 4'd2) begin errors++; $display("[TB] FAIL rstmid_next_cnt: got %0d want 2", cnt); end
        checks++; if (rxCh.size() != 2) begin errors++; $display("[TB] FAIL rstmid_rx_size: got %0d want 2", rxCh.size()); end
        if (rxCh.size() == 2) begin
            checks++; if (rxCh[0] != 1) begin errors++; $display("[TB] FAIL rstmid_ptr_ch0: got %0d want 1", rxCh[0]); end
            checks++; if (rxCh[1] != 4) begin errors++; $display("[TB] FAIL rstmid_ptr_ch1: got %0d want 4", rxCh[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_early_close();
        test_empty_frame();
        test_stop_mask();
        test_stall();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
